// File: rtl/conv_window_scheduler_if.sv
// Handshake and buffer-strobe bundle between the convolution window scheduler
// and its surroundings (stream sources, buffers, MAC datapath, OFM consumer).
interface conv_window_scheduler_if #(
  parameter int IFM_W = 7,
  parameter int K     = 3
);
  localparam int N_IFM = IFM_W * IFM_W;
  localparam int N_TAP = K * K;
  localparam int OFM_W = IFM_W - K + 1;
  localparam int AW    = $clog2(N_IFM);
  localparam int WW    = $clog2(N_TAP);
  localparam int OW    = $clog2(OFM_W * OFM_W);

  logic          in_valid;
  logic          weight_valid;
  logic          out_ready;
  logic          ifm_we;
  logic [AW-1:0] ifm_waddr;
  logic          w_we;
  logic [WW-1:0] w_waddr;
  logic [AW-1:0] rd_ifm_addr;
  logic [WW-1:0] rd_w_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          out_valid;
  logic [OW-1:0] ofm_idx;
  logic          busy;
  logic          done;
  logic          drop;

  // scheduler side
  modport master (
    input  in_valid, weight_valid, out_ready,
    output ifm_we, ifm_waddr, w_we, w_waddr,
           rd_ifm_addr, rd_w_addr, mac_en, mac_clr, mac_last,
           out_valid, ofm_idx, busy, done, drop
  );

  // environment side: sample sources, datapath and OFM consumer
  modport slave (
    output in_valid, weight_valid, out_ready,
    input  ifm_we, ifm_waddr, w_we, w_waddr,
           rd_ifm_addr, rd_w_addr, mac_en, mac_clr, mac_last,
           out_valid, ofm_idx, busy, done, drop
  );
endinterface

// File: rtl/conv_window_scheduler.sv
// Sequencer for the shared 3x3 convolution MAC datapath: loads the IFM and
// weight buffers from two independent streams, then walks every valid output
// position issuing one tap per cycle and presents each result to the consumer.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for the first IFM or weight sample of a frame
// LOAD  | writing IFM / weight samples until both buffers are full
// CALC  | issuing the K*K taps of the current output window
// HOLD  | accumulator holds a finished value, waiting for out_ready
// DONE  | one-cycle frame-complete pulse, counters cleared
module conv_window_scheduler #(
  parameter int IFM_W = 7,
  parameter int K     = 3
) (
  input  logic clk,
  input  logic rst,
  conv_window_scheduler_if.master bus
);
  localparam int OFM_W = IFM_W - K + 1;
  localparam int N_IFM = IFM_W * IFM_W;
  localparam int N_TAP = K * K;
  localparam int AW    = $clog2(N_IFM);
  localparam int WW    = $clog2(N_TAP);
  localparam int OW    = $clog2(OFM_W * OFM_W);
  // load counters must be able to hold the "full" value itself
  localparam int CW    = $clog2(N_IFM + 1);
  localparam int TW    = $clog2(N_TAP + 1);
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int RW    = (OFM_W > 1) ? $clog2(OFM_W) : 1;

  localparam logic [CW-1:0] IFM_FULL  = CW'(N_IFM);
  localparam logic [TW-1:0] W_FULL    = TW'(N_TAP);
  localparam logic [WW-1:0] T_LAST    = WW'(N_TAP - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);
  localparam logic [RW-1:0] O_LAST    = RW'(OFM_W - 1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(IFM_W);
  localparam logic [OW-1:0] OROW_STEP = OW'(OFM_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_HOLD, S_DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] ifm_cnt, ifm_cnt_n;
  logic [TW-1:0] w_cnt, w_cnt_n;
  logic [WW-1:0] t, t_n;
  logic [KW-1:0] tr, tr_n, tc, tc_n;
  logic [RW-1:0] orow, orow_n, ocol, ocol_n;

  logic          loading;
  logic          ifm_wr;
  logic          w_wr;

  logic [AW-1:0] rd_ifm_addr_q, rd_ifm_addr_n;
  logic [WW-1:0] rd_w_addr_q, rd_w_addr_n;
  logic          mac_en_q, mac_en_n;
  logic          mac_clr_q, mac_clr_n;
  logic          mac_last_q, mac_last_n;
  logic          out_valid_q, out_valid_n;
  logic [OW-1:0] ofm_idx_q, ofm_idx_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          drop_q, drop_n;

  // Write path: the only combinational input-to-output route; gated off in reset.
  always_comb begin
    loading = (state == S_IDLE) || (state == S_LOAD);
    ifm_wr  = !rst && loading && bus.in_valid     && (ifm_cnt < IFM_FULL);
    w_wr    = !rst && loading && bus.weight_valid && (w_cnt < W_FULL);
    drop_n  = (bus.in_valid && !ifm_wr) || (bus.weight_valid && !w_wr);
  end

  assign bus.ifm_we    = ifm_wr;
  assign bus.ifm_waddr = ifm_cnt[AW-1:0];
  assign bus.w_we      = w_wr;
  assign bus.w_waddr   = w_cnt[WW-1:0];

  // Next-state and counter update.
  always_comb begin
    state_n   = state;
    ifm_cnt_n = ifm_cnt + CW'(ifm_wr);
    w_cnt_n   = w_cnt + TW'(w_wr);
    t_n       = t;
    tr_n      = tr;
    tc_n      = tc;
    orow_n    = orow;
    ocol_n    = ocol;
    case (state)
      S_IDLE: begin
        if (bus.in_valid || bus.weight_valid) state_n = S_LOAD;
      end
      S_LOAD: begin
        // decided on post-write counts so the first tap follows the last write
        if ((ifm_cnt_n == IFM_FULL) && (w_cnt_n == W_FULL)) begin
          state_n = S_CALC;
          t_n     = '0;
          tr_n    = '0;
          tc_n    = '0;
        end
      end
      S_CALC: begin
        if (t == T_LAST) begin
          state_n = S_HOLD;
        end else begin
          t_n = t + WW'(1);
          if (tc == K_LAST) begin
            tc_n = '0;
            tr_n = tr + KW'(1);
          end else begin
            tc_n = tc + KW'(1);
          end
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          if ((orow == O_LAST) && (ocol == O_LAST)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_CALC;
            t_n     = '0;
            tr_n    = '0;
            tc_n    = '0;
            if (ocol == O_LAST) begin
              ocol_n = '0;
              orow_n = orow + RW'(1);
            end else begin
              ocol_n = ocol + RW'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_n   = S_IDLE;
        ifm_cnt_n = '0;
        w_cnt_n   = '0;
        t_n       = '0;
        tr_n      = '0;
        tc_n      = '0;
        orow_n    = '0;
        ocol_n    = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output values decoded from the next state so every output is a flop.
  always_comb begin
    rd_ifm_addr_n = '0;
    rd_w_addr_n   = '0;
    mac_en_n      = 1'b0;
    mac_clr_n     = 1'b0;
    mac_last_n    = 1'b0;
    out_valid_n   = 1'b0;
    ofm_idx_n     = '0;
    busy_n        = state_n inside {S_LOAD, S_CALC, S_HOLD};
    done_n        = (state_n == S_DONE);
    if (state_n == S_CALC) begin
      rd_ifm_addr_n = AW'(orow_n) * ROW_STEP + AW'(ocol_n)
                    + AW'(tr_n) * ROW_STEP + AW'(tc_n);
      rd_w_addr_n   = t_n;
      mac_en_n      = 1'b1;
      mac_clr_n     = (t_n == '0);
      mac_last_n    = (t_n == T_LAST);
    end
    if (state_n == S_HOLD) begin
      out_valid_n = 1'b1;
      ofm_idx_n   = OW'(orow_n) * OROW_STEP + OW'(ocol_n);
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ifm_cnt <= '0;
      w_cnt   <= '0;
      t       <= '0;
      tr      <= '0;
      tc      <= '0;
      orow    <= '0;
      ocol    <= '0;
    end else begin
      state   <= state_n;
      ifm_cnt <= ifm_cnt_n;
      w_cnt   <= w_cnt_n;
      t       <= t_n;
      tr      <= tr_n;
      tc      <= tc_n;
      orow    <= orow_n;
      ocol    <= ocol_n;
    end
  end

  // Registered (Moore) outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ifm_addr_q <= '0;
      rd_w_addr_q   <= '0;
      mac_en_q      <= 1'b0;
      mac_clr_q     <= 1'b0;
      mac_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      ofm_idx_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      rd_ifm_addr_q <= rd_ifm_addr_n;
      rd_w_addr_q   <= rd_w_addr_n;
      mac_en_q      <= mac_en_n;
      mac_clr_q     <= mac_clr_n;
      mac_last_q    <= mac_last_n;
      out_valid_q   <= out_valid_n;
      ofm_idx_q     <= ofm_idx_n;
      busy_q        <= busy_n;
      done_q        <= done_n;
      drop_q        <= drop_n;
    end
  end

  assign bus.rd_ifm_addr = rd_ifm_addr_q;
  assign bus.rd_w_addr   = rd_w_addr_q;
  assign bus.mac_en      = mac_en_q;
  assign bus.mac_clr     = mac_clr_q;
  assign bus.mac_last    = mac_last_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.ofm_idx     = ofm_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.drop        = drop_q;
endmodule
